// File: rtl/led_step_ctrl.sv
// Running-light step controller: three debounced active-low keys drive a
// run/stop FSM, a direction flag and a 4-level speed select for a step ticker.
module led_step_ctrl #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned BASE_DIV   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_run_n,
    input  logic       key_dir_n,
    input  logic       key_spd_n,
    output logic       step,
    output logic       dir,
    output logic       running,
    output logic [1:0] speed
);

    localparam int unsigned CW       = $clog2(8 * BASE_DIV);
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Key vectors are indexed 0 = run, 1 = dir, 2 = speed.
    logic [2:0]    key_raw;
    logic [2:0]    sync1, sync2;
    logic [2:0]    acc, acc_d;
    logic [2:0]    block;
    logic [2:0]    press;
    logic [15:0]   deb_cnt [3];
    logic [1:0]    settle;
    logic [CW-1:0] tick_cnt;
    logic [31:0]   period;
    logic          tc;

    assign key_raw = {key_spd_n, key_dir_n, key_run_n};

    // A key still held when reset ends stays blocked until it has been seen
    // released, so its forced-high-to-low transition after reset is not a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            acc    <= '1;
            acc_d  <= '1;
            block  <= '1;
            press  <= '0;
            settle <= '0;
            for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
        end else begin
            sync1  <= key_raw;
            sync2  <= sync1;
            acc_d  <= acc;
            settle <= {settle[0], 1'b1};
            press  <= acc_d & ~acc & ~block;
            block  <= block & ~({3{settle[1]}} & acc & sync2);
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == acc[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    acc[k]     <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (press[0]) state_nxt = (state == RUN) ? STOP : RUN;
    end

    assign running = (state == RUN);

    always_comb begin
        period = BASE_DIV << (2'd3 - speed);
        tc     = (tick_cnt == CW'(period - 32'd1));
    end

    // A speed press restarts the period; a pause landing on terminal count
    // or a period of one cycle must not produce a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOP;
            dir      <= 1'b0;
            speed    <= 2'd0;
            tick_cnt <= '0;
            step     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (press[1]) dir <= ~dir;
            if (press[2]) speed <= speed + 2'd1;
            if (press[2]) begin
                tick_cnt <= '0;
                step     <= 1'b0;
            end else if (running && tc) begin
                tick_cnt <= '0;
                step     <= ~press[0] & ~step;
            end else begin
                if (running) tick_cnt <= tick_cnt + CW'(1);
                step <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Bench for led_step_ctrl: directed scenarios plus a randomized key sequence
// checked against a window-based debounce and period model.
module tb_led_step_ctrl;

    localparam int DEB  = 4;
    localparam int BDIV = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_run_n = 1'b1;
    logic       key_dir_n = 1'b1;
    logic       key_spd_n = 1'b1;
    logic       step, dir, running;
    logic [1:0] speed;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;

    led_step_ctrl #(.DEB_CYCLES(DEB), .BASE_DIV(BDIV)) dut (
        .clk(clk), .rst(rst), .key_run_n(key_run_n), .key_dir_n(key_dir_n),
        .key_spd_n(key_spd_n), .step(step), .dir(dir), .running(running), .speed(speed)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a key level is accepted once the last DEB synchronized
    // samples all disagree with it; a press takes effect two edges later.
    bit         hist [3][$];
    bit         acc_m [3];
    bit         blocked [3];
    bit         pend1 [3];
    bit         pend2 [3];
    bit         m_running, m_dir, m_step;
    logic [1:0] m_speed;
    int         m_phase;
    int         since_rst;

    task automatic model_edge();
        bit pr [3];
        bit raw [3];
        bit all_diff, fall;
        int p;
        raw[0] = key_run_n;
        raw[1] = key_dir_n;
        raw[2] = key_spd_n;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                hist[k].delete();
                repeat (DEB + 2) hist[k].push_back(1'b1);
                acc_m[k] = 1'b1;
                blocked[k] = 1'b1;
                pend1[k] = 1'b0;
                pend2[k] = 1'b0;
            end
            m_running = 0; m_dir = 0; m_speed = 0; m_phase = 0; m_step = 0;
            since_rst = 0;
            return;
        end
        since_rst++;
        for (int k = 0; k < 3; k++) begin
            pr[k] = pend2[k];
            hist[k].push_back(raw[k]);
            void'(hist[k].pop_front());
            if (since_rst >= 3 && acc_m[k] && hist[k][DEB-1]) blocked[k] = 1'b0;
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) if (hist[k][i] == acc_m[k]) all_diff = 1'b0;
            fall = 1'b0;
            if (all_diff) begin
                fall = acc_m[k];
                acc_m[k] = !acc_m[k];
            end
            pend2[k] = pend1[k];
            pend1[k] = fall && !blocked[k];
        end
        p = BDIV * (8 >> m_speed);
        if (pr[2]) begin
            m_phase = 0;
            m_step = 0;
        end else if (m_running) begin
            if (m_phase == p - 1) begin
                m_phase = 0;
                m_step = !pr[0] && !m_step;
            end else begin
                m_phase++;
                m_step = 0;
            end
        end else begin
            m_step = 0;
        end
        if (pr[0]) m_running = !m_running;
        if (pr[1]) m_dir = !m_dir;
        if (pr[2]) m_speed = m_speed + 2'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        edge_no++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int steps = 0;
        int bad = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (step) steps++;
            if (running !== 1'b0 || speed !== 2'd0 || dir !== 1'b0) bad++;
        end
        n_tests++; if (steps !== 0) begin n_fail++; $display("FAIL reset_steps: got %0d expected 0", steps); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL reset_outputs: %0d bad cycles expected 0", bad); end
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0b expected 0", running); end
        n_tests++; if (speed !== 2'd0) begin n_fail++; $display("FAIL reset_speed: got %0d expected 0", speed); end
        n_tests++; if (dir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %0b expected 0", dir); end
    endtask

    task automatic test_run_hold();
        logic [15:0] exp_q [$] = '{16'd55, 16'd103, 16'd151};
        int got_q [$];
        int mm = 0;
        key_run_n = 1'b0;
        for (int e = 0; e <= 160; e++) begin
            tick();
            if (e == 6) begin
                n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL run_edge6: got %0b expected 0", running); end
            end
            if (e == 7) begin
                n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_edge7: got %0b expected 1", running); end
            end
            if (step) got_q.push_back(e);
            if ({step, running, dir, speed} !== {m_step, m_running, m_dir, m_speed}) mm++;
        end
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL run_step_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[i] != int'(exp_q[i])) begin
                    n_fail++; $display("FAIL run_step_edge%0d: got %0d expected %0d", i, got_q[i], exp_q[i]);
                end
            end
        end
        n_tests++; if (mm !== 0) begin n_fail++; $display("FAIL run_model: %0d mismatching cycles expected 0", mm); end
        key_run_n = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_bounce();
        bit   pat [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int   toggles = 0;
        int   tog_e = -1;
        logic prev;
        prev = running;
        for (int e = 0; e < 30; e++) begin
            key_run_n = (e < 8) ? pat[e] : 1'b0;
            tick();
            if (running !== prev) begin toggles++; tog_e = e; prev = running; end
        end
        n_tests++; if (toggles !== 1) begin n_fail++; $display("FAIL bounce_toggles: got %0d expected 1", toggles); end
        n_tests++; if (tog_e !== 15) begin n_fail++; $display("FAIL bounce_edge: got %0d expected 15", tog_e); end
        n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL bounce_running: got %0b expected 0", running); end
        key_run_n = 1'b1;
        repeat (15) tick();
    endtask

    task automatic test_speed();
        int t0 = 0, t1 = 0, e_sp = 0, t2 = 0;
        bit g0 = 0, g1 = 0, ge = 0, g2 = 0;
        key_run_n = 1'b0; repeat (10) tick();
        key_run_n = 1'b1; repeat (10) tick();
        n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL speed_start_running: got %0b expected 1", running); end
        repeat (3) begin
            key_spd_n = 1'b0; repeat (8) tick();
            key_spd_n = 1'b1; repeat (8) tick();
        end
        n_tests++; if (speed !== 2'd3) begin n_fail++; $display("FAIL speed_three: got %0d expected 3", speed); end
        for (int i = 0; i < 30 && !g0; i++) begin tick(); if (step === 1'b1) begin g0 = 1; t0 = edge_no; end end
        for (int i = 0; i < 20 && !g1; i++) begin tick(); if (step === 1'b1) begin g1 = 1; t1 = edge_no; end end
        n_tests++;
        if (!g0 || !g1 || t1 - t0 != 6) begin
            n_fail++; $display("FAIL speed3_period: got %0d (found %0b%0b) expected 6", t1 - t0, g0, g1);
        end
        key_spd_n = 1'b0;
        for (int i = 0; i < 20 && !ge; i++) begin tick(); if (speed !== 2'd3) begin ge = 1; e_sp = edge_no; end end
        key_spd_n = 1'b1;
        n_tests++; if (!ge || speed !== 2'd0) begin n_fail++; $display("FAIL speed_wrap: got %0d expected 0", speed); end
        for (int i = 0; i < 60 && !g2; i++) begin tick(); if (step === 1'b1) begin g2 = 1; t2 = edge_no; end end
        n_tests++;
        if (!g2 || t2 - e_sp != 48) begin
            n_fail++; $display("FAIL speed0_restart: got %0d (found %0b) expected 48", t2 - e_sp, g2);
        end
    endtask

    task automatic test_dir_pause();
        int  s0 = 0, s1 = 0, s2 = 0, a = 0, r = 0, t = 0;
        bit  g0 = 0, gd = 0, g1 = 0, g2 = 0, ga = 0, gr = 0, gt = 0;
        int  stop_steps = 0;
        for (int i = 0; i < 60 && !g0; i++) begin tick(); if (step === 1'b1) begin g0 = 1; s0 = edge_no; end end
        key_dir_n = 1'b0;
        for (int i = 0; i < 20 && !gd; i++) begin tick(); if (dir !== 1'b0) gd = 1; end
        key_dir_n = 1'b1;
        n_tests++; if (!gd || dir !== 1'b1) begin n_fail++; $display("FAIL dir_flip: got %0b expected 1", dir); end
        for (int i = 0; i < 60 && !g1; i++) begin tick(); if (step === 1'b1) begin g1 = 1; s1 = edge_no; end end
        for (int i = 0; i < 60 && !g2; i++) begin tick(); if (step === 1'b1) begin g2 = 1; s2 = edge_no; end end
        n_tests++;
        if (!g0 || !g1 || !g2 || s1 - s0 != 48 || s2 - s1 != 48) begin
            n_fail++; $display("FAIL dir_cadence: got gaps %0d,%0d expected 48,48", s1 - s0, s2 - s1);
        end
        key_run_n = 1'b0;
        for (int i = 0; i < 20 && !ga; i++) begin tick(); if (running === 1'b0) begin ga = 1; a = edge_no; end end
        key_run_n = 1'b1;
        repeat (100) begin tick(); if (step) stop_steps++; end
        key_run_n = 1'b0;
        for (int i = 0; i < 20 && !gr; i++) begin
            tick();
            if (running === 1'b1) begin gr = 1; r = edge_no; end
            else if (step) stop_steps++;
        end
        key_run_n = 1'b1;
        n_tests++; if (!ga || !gr) begin n_fail++; $display("FAIL pause_toggle: got pause %0b resume %0b expected 1 1", ga, gr); end
        n_tests++; if (stop_steps !== 0) begin n_fail++; $display("FAIL pause_steps: got %0d expected 0", stop_steps); end
        for (int i = 0; i < 60 && !gt; i++) begin tick(); if (step === 1'b1) begin gt = 1; t = edge_no; end end
        n_tests++;
        if (!gt || (a - s2) + (t - r) != 48) begin
            n_fail++; $display("FAIL pause_resume_count: got %0d run cycles expected 48", (a - s2) + (t - r));
        end
    endtask

    task automatic test_reset_mid();
        int run_hi = 0;
        repeat (2) begin
            key_spd_n = 1'b0; repeat (8) tick();
            key_spd_n = 1'b1; repeat (8) tick();
        end
        n_tests++;
        if ({running, dir, speed} !== 4'b1110) begin
            n_fail++; $display("FAIL rstmid_setup: got %b expected 1110", {running, dir, speed});
        end
        key_run_n = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({step, running, dir, speed} !== 5'b00000) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b expected 00000", {step, running, dir, speed});
        end
        repeat (30) begin tick(); if (running) run_hi++; end
        key_run_n = 1'b1;
        repeat (15) begin tick(); if (running) run_hi++; end
        n_tests++; if (run_hi !== 0) begin n_fail++; $display("FAIL rstmid_held_key: %0d running cycles expected 0", run_hi); end
        key_run_n = 1'b0; repeat (10) tick();
        key_run_n = 1'b1; repeat (5) tick();
        n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL rstmid_repress: got %0b expected 1", running); end
    endtask

    task automatic test_random();
        logic [3:0] sched [$];
        logic [2:0] lvl;
        int         len;
        for (int s = 0; s < 60; s++) begin
            lvl = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 14);
            repeat (len) sched.push_back({1'b0, lvl});
            if (s == 40) sched.push_back({1'b1, lvl});
        end
        foreach (sched[i]) begin
            rst = sched[i][3];
            {key_spd_n, key_dir_n, key_run_n} = sched[i][2:0];
            tick();
            n_tests++;
            if ({step, running, dir, speed} !== {m_step, m_running, m_dir, m_speed}) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b expected %b", i,
                         {step, running, dir, speed}, {m_step, m_running, m_dir, m_speed});
            end
        end
        rst = 1'b0;
        {key_spd_n, key_dir_n, key_run_n} = 3'b111;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_run_hold();
        test_bounce();
        test_speed();
        test_dir_pause();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_step_ctrl.md
LED_STEP_CTRL -- requirements
Module: led_step_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive stable cycles required to accept a key level (range 1..65535).
REQ-002 SHALL have parameter BASE_DIV, default 6: step period in clk cycles at the fastest speed (range 1..2^24).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port key_run_n, input, 1 bit: raw asynchronous run/pause button, active-low, bouncy.
REQ-006 SHALL have port key_dir_n, input, 1 bit: raw asynchronous direction button, active-low, bouncy.
REQ-007 SHALL have port key_spd_n, input, 1 bit: raw asynchronous speed button, active-low, bouncy.
REQ-008 SHALL have port step, output, 1 bit: one-cycle pulse that advances the downstream running-light stage by one position.
REQ-009 SHALL have port dir, output, 1 bit: 0 = shift toward bit 7, 1 = shift toward bit 0; held level.
REQ-010 SHALL have port running, output, 1 bit: 1 in RUN state, 0 in STOP state.
REQ-011 SHALL have port speed, output, 2 bits: current speed level, 0 slowest to 3 fastest.

Function
REQ-012 SHALL pass each key through a 2-flop synchronizer before any other logic.
REQ-013 SHALL debounce each key independently: an accepted-level register changes only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles; any cycle of agreement clears that key's counter.
REQ-014 SHALL generate a press event only on an accepted-level 1->0 transition; releases generate nothing; a held key generates exactly one event.
REQ-015 SHALL register the effect of a press (running/dir/speed change) at rising edge DEB_CYCLES+3, counted from the first edge that samples the new raw level, provided the raw level stays stable.
REQ-016 SHALL implement a two-state FSM: STOP (running=0) and RUN (running=1); a run press toggles STOP<->RUN; there are no other transitions.
REQ-017 SHALL toggle dir on each dir press, in either state.
REQ-018 SHALL increment speed on each speed press, wrapping 3->0, in either state.
REQ-019 SHALL set the step period P = BASE_DIV * 2^(3-speed) cycles: speed 0 gives 8*BASE_DIV, and speed 3 gives BASE_DIV.
REQ-020 SHALL count the tick counter 0..P-1 only in RUN; step=1 in the cycle after the counter reaches P-1, and the counter returns to 0 at that edge.
REQ-021 SHALL hold the tick counter (not clear it) while in STOP and resume from the held value on re-entering RUN.
REQ-022 SHALL clear the tick counter to 0 on a speed press; if a speed press and terminal count coincide, the speed press wins and no step is issued that cycle.
REQ-023 SHALL apply simultaneous presses on different keys all in the same cycle; a dir press never affects step timing.
REQ-024 SHALL make step a single-cycle pulse, never asserted for two consecutive cycles; step SHALL NOT assert in STOP.
REQ-025 SHALL size the tick counter to hold 8*BASE_DIV-1 without overflow.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, set running=0 (STOP), dir=0, speed=0, step=0, and clear the tick counter and all debounce counters.
REQ-027 SHALL, on reset, set the synchronizer flops and accepted levels to 1 (released), so a key held through reset generates no press until it is released and pressed again.
REQ-028 SHALL give rst priority over every press and tick event in the same cycle.

Verification
REQ-029 SHALL cover: reset, keys released, 200 cycles -> running=0, step never 1, speed=0, dir=0.
REQ-030 SHALL cover: DEB_CYCLES=4, BASE_DIV=6, key_run_n held low from edge 0 -> running=1 at edge 7; steps thereafter exactly every 48 cycles.
REQ-031 SHALL cover: key_run_n bounce pattern low3/high1/low3/high1 then stable low -> exactly one toggle, occurring 7 edges after the final stable low begins.
REQ-032 SHALL cover: while running, 3 clean speed presses -> speed=3 and step period 6; a 4th press -> speed=0, period 48, with counter restart so the first step comes 48 cycles after the press takes effect.
REQ-033 SHALL cover: a dir press mid-run -> dir flips, step cadence unchanged; then a run press (pause) for 100 cycles, then another run press -> no steps during STOP, and the counter resumes from its held value.
REQ-034 SHALL cover: rst pulsed for 1 cycle mid-run with speed=2 and dir=1 -> all outputs at reset values after that edge; key held low through reset -> no toggle until it is released and pressed again.
